rd_collect: RTL and testbench

Downstream read-data collector for the read-control FSM: captures `rdata` on every cycle the FSM asserts `rd`, tags the final word of each transaction when the FSM asserts `ds`, and buffers `{last, data}` entries in a small FIFO. The consumer drains them over a valid/ready interface. Sticky flags report dropped words and FSM protocol violations.

---
 rtl/rd_pkg.sv | 12 +
 rtl/rd_fifo.sv | 59 +++++
 rtl/rd_collect.sv | 102 ++++++++++
 tb/tb_rd_collect.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_pkg.sv
// Shared types and defaults for the read-data collector.
package rd_pkg;

    localparam int RD_DATA_W = 8;
    localparam int RD_DEPTH  = 8;

    typedef struct packed {
        logic                 last;
        logic [RD_DATA_W-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/rd_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module rd_fifo
    import rd_pkg::*;
#(
    parameter int W     = RD_DATA_W + 1,
    parameter int DEPTH = RD_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          pop;
    logic          acc;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign pop     = pop_i & ~empty_o;
    assign acc     = push_i & (~full_o | pop);
    assign level_d = level_q + LW'(acc) - LW'(pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (acc) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/rd_collect.sv
// Collects FSM read data into {last, data} entries; a word is staged
// until the next rd or ds tells whether it ends the transaction.
module rd_collect
    import rd_pkg::*;
#(
    parameter int DATA_W = RD_DATA_W,
    parameter int DEPTH  = RD_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd,
    input  logic                   ds,
    input  logic [DATA_W-1:0]      rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   proto_err,
    input  logic                   err_clr
);

    logic [DATA_W-1:0] stg_data_q;
    logic [DATA_W-1:0] stg_data_d;
    logic              stg_vld_q;
    logic              stg_vld_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              perr_q;
    logic              perr_d;

    logic              push;
    logic              push_last;
    logic              perr_set;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;

    always_comb begin
        push       = 1'b0;
        push_last  = 1'b0;
        perr_set   = 1'b0;
        stg_vld_d  = stg_vld_q;
        stg_data_d = stg_data_q;
        if (rd) begin
            push       = stg_vld_q;
            stg_vld_d  = 1'b1;
            stg_data_d = rdata;
            perr_set   = ds;
        end else if (ds) begin
            push      = stg_vld_q;
            push_last = 1'b1;
            stg_vld_d = 1'b0;
            perr_set  = ~stg_vld_q;
        end
    end

    // A pop in the same cycle frees the slot, so only then is a full push safe.
    assign pop        = out_ready & ~fifo_empty;
    assign drop       = push & fifo_full & ~pop;
    assign overflow_d = drop | (overflow_q & ~err_clr);
    assign perr_d     = perr_set | (perr_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_data_q <= '0;
            stg_vld_q  <= 1'b0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            stg_data_q <= stg_data_d;
            stg_vld_q  <= stg_vld_d;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
        end
    end

    rd_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({push_last, stg_data_q}),
        .pop_i   (out_ready),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid = ~fifo_empty;
    assign out_last  = fifo_head[DATA_W];
    assign out_data  = fifo_head[DATA_W-1:0];
    assign overflow  = overflow_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_rd_collect.sv
// Randomised scoreboard bench for rd_collect with directed scenarios.
module tb_rd_collect;
    import rd_pkg::*;

    localparam int DW = RD_DATA_W;
    localparam int DP = RD_DEPTH;
    localparam int LW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd = 1'b0;
    logic          ds = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [LW-1:0] level;
    logic          overflow;
    logic          proto_err;
    logic          err_clr = 1'b0;

    rd_collect #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .ds        (ds),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level),
        .overflow  (overflow),
        .proto_err (proto_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected entries, occupancy, pending word, flags.
    rd_entry_t     scb[$];
    int            m_lvl = 0;
    bit            m_ovf = 0;
    bit            m_perr = 0;
    bit            m_has = 0;
    logic [DW-1:0] m_stg = '0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_lvl != 0));
        chk("level", int'(level), m_lvl);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("proto_err", int'(proto_err), int'(m_perr));
        if (out_valid) begin
            if (scb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL head: got data %0h with no entry expected", out_data);
            end else begin
                chk("out_data", int'(out_data), int'(scb[0].data));
                chk("out_last", int'(out_last), int'(scb[0].last));
                if (out_ready) void'(scb.pop_front());
            end
        end
    end

    task automatic model_update(input bit r, input bit d, input logic [DW-1:0] dat,
                                input bit rdy, input bit clr);
        bit            pop;
        bit            psh;
        bit            lst;
        bit            oset;
        bit            pset;
        logic [DW-1:0] pd;
        pop  = rdy && (m_lvl > 0);
        psh  = 0;
        lst  = 0;
        oset = 0;
        pset = 0;
        pd   = '0;
        if (r) begin
            if (m_has) begin
                psh = 1;
                pd  = m_stg;
            end
            m_stg = dat;
            m_has = 1;
            pset  = d;
        end else if (d) begin
            if (m_has) begin
                psh   = 1;
                lst   = 1;
                pd    = m_stg;
                m_has = 0;
            end else begin
                pset = 1;
            end
        end
        if (psh) begin
            if (m_lvl < DP || pop) begin
                scb.push_back('{last: lst, data: pd});
                m_lvl++;
            end else begin
                oset = 1;
            end
        end
        if (pop) m_lvl--;
        m_ovf  = oset || (m_ovf && !clr);
        m_perr = pset || (m_perr && !clr);
    endtask

    task automatic step(input bit r, input bit d, input logic [DW-1:0] dat,
                        input bit rdy, input bit clr);
        rd        = r;
        ds        = d;
        rdata     = dat;
        out_ready = rdy;
        err_clr   = clr;
        @(posedge clk);
        #1;
        if (rst_n) model_update(r, d, dat, rdy, clr);
    endtask

    task automatic do_reset();
        rd        = 1'b0;
        ds        = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        scb.delete();
        m_lvl  = 0;
        m_ovf  = 0;
        m_perr = 0;
        m_has  = 0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // single-word transaction with FSM timing
        step(1, 0, 8'h11, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        chk("t1_level", int'(level), 1);
        chk("t1_data", int'(out_data), 'h11);
        chk("t1_last", int'(out_last), 1);
        chk("t1_perr", int'(proto_err), 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t1_drained", int'(level), 0);

        // three-word transaction, consumer always ready
        step(1, 0, 8'hA1, 1, 0);
        step(1, 0, 8'hA2, 1, 0);
        step(1, 0, 8'hA3, 1, 0);
        step(0, 1, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t2_level", int'(level), 0);

        // overflow: nine single-word transactions into eight slots
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 8'(8'h30 + i), 0, 0);
            step(0, 1, 8'h00, 0, 0);
        end
        chk("t3_level", int'(level), 8);
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_head", int'(out_data), 'h30);
        step(0, 0, 8'h00, 0, 1);
        chk("t3_clr", int'(overflow), 0);

        // push while full with a pop in the same cycle
        step(1, 0, 8'h50, 0, 0);
        step(0, 1, 8'h00, 1, 0);
        chk("t4_level", int'(level), 8);
        chk("t4_overflow", int'(overflow), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0);
        chk("t4_drained", int'(level), 0);

        // protocol errors
        step(0, 1, 8'h00, 0, 0);
        chk("t5_perr_ds", int'(proto_err), 1);
        chk("t5_nopush", int'(level), 0);
        step(0, 0, 8'h00, 0, 1);
        chk("t5_clr", int'(proto_err), 0);
        step(1, 1, 8'h77, 0, 0);
        chk("t5_perr_rdds", int'(proto_err), 1);
        step(0, 1, 8'h00, 0, 0);
        chk("t5_staged", int'(out_data), 'h77);
        step(0, 0, 8'h00, 1, 1);
        chk("t5_clr2", int'(proto_err), 0);

        // reset mid-transaction, then a clean transaction
        step(1, 0, 8'h81, 0, 0);
        step(1, 0, 8'h82, 0, 0);
        do_reset();
        step(1, 0, 8'h99, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        chk("t6_level", int'(level), 1);
        chk("t6_data", int'(out_data), 'h99);
        chk("t6_last", int'(out_last), 1);
        step(0, 0, 8'h00, 1, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(1) == 1,
                     $urandom_range(3) == 0,
                     8'($urandom),
                     $urandom_range(9) < 6,
                     $urandom_range(19) == 0);
            end
        end
        for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 1, 0);
        chk("final_level", int'(level), 0);
        chk("final_scb", scb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
